td4_prog_loader: RTL and testbench

- Serial program loader and port arbiter for the TD4 16-word x 8-bit program memory.
- Accepts program bytes over a slow two-wire serial input (sclk_in/sdata_in, sampled in the core clock domain) and writes them into consecutive memory words.
- Holds the CPU halted while loading; multiplexes the memory address between the CPU PC and its own write pointer.
- Sits between the pad-facing inputs, the CPU core and the program memory.

---
 rtl/td4_pkg.sv | 21 ++
 rtl/td4_sync_edge.sv | 42 ++++
 rtl/td4_prog_loader.sv | 125 ++++++++++++
 tb/tb_td4_prog_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program loader: FSM state encoding,
// bus widths and the byte-to-nibble split used when writing program memory.
package td4_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } td4_state_t;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  // Immediate occupies the high nibble of a program byte, opcode the low nibble.
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 4;
  localparam int OPC_HI = 3;
  localparam int OPC_LO = 0;

endpackage

// File: rtl/td4_sync_edge.sv
// N-stage synchronizer for an asynchronous pad input, with an optional
// single-cycle pulse on the synchronized rising edge.
module td4_sync_edge #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_level = r_sync[STAGES-1];

  generate
    if (EDGE) begin : g_edge
      logic r_prev;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= o_level;
        end
      end
      assign o_rise = o_level & ~r_prev;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/td4_prog_loader.sv
// Serial program loader for the TD4 16x8 program memory: shifts bytes in over
// a two-wire serial link, writes consecutive words and holds the CPU meanwhile.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORDS       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic              sclk_in,
  input  logic              sdata_in,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_opcode,
  output logic [3:0]        mem_immediate,
  output logic              mem_write,
  output logic              cpu_run,
  output logic              load_done,
  output logic [3:0]        word_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(WORDS - 1);

  td4_state_t        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [2:0]        r_bitcnt;
  logic [DATA_W-1:0] r_shreg;
  logic [3:0]        r_word_cnt;

  logic w_ld_sync;
  logic w_ld_rise_unused;
  logic w_sclk_sync_unused;
  logic w_sclk_rise;
  logic w_sdata_sync;
  logic w_sdata_rise_unused;

  td4_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_ld (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (ld_en),
    .o_level (w_ld_sync),
    .o_rise  (w_ld_rise_unused)
  );

  td4_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_sclk (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (sclk_in),
    .o_level (w_sclk_sync_unused),
    .o_rise  (w_sclk_rise)
  );

  td4_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_sdata (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (sdata_in),
    .o_level (w_sdata_sync),
    .o_rise  (w_sdata_rise_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_ptr      <= '0;
      r_bitcnt   <= '0;
      r_shreg    <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_ld_sync) begin
            r_state    <= ST_LOAD;
            r_ptr      <= '0;
            r_bitcnt   <= '0;
            r_word_cnt <= '0;
          end
        end
        ST_LOAD: begin
          // Dropping ld_en discards the partial byte; the shift is skipped.
          if (!w_ld_sync) begin
            r_state <= ST_RUN;
          end else if (w_sclk_rise) begin
            r_shreg  <= {r_shreg[DATA_W-2:0], w_sdata_sync};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_ptr    <= r_ptr + 1'b1;
          r_bitcnt <= '0;
          // 16 does not fit in four bits, so a full load reads back as 4'hF.
          if (r_word_cnt != 4'hF) begin
            r_word_cnt <= r_word_cnt + 4'd1;
          end
          if (!w_ld_sync) begin
            r_state <= ST_RUN;
          end else if (r_ptr == LAST_PTR) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          if (!w_ld_sync) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign mem_address   = (r_state == ST_RUN) ? cpu_pc : r_ptr;
  assign mem_immediate = r_shreg[IMM_HI:IMM_LO];
  assign mem_opcode    = r_shreg[OPC_HI:OPC_LO];
  assign mem_write     = (r_state == ST_WRITE);
  assign cpu_run       = (r_state == ST_RUN);
  assign load_done     = (r_state == ST_DONE);
  assign word_cnt      = r_word_cnt;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: serial byte driver, memory model,
// write scoreboard with expected queue, and a final summary line.
module tb_td4_prog_loader;

  localparam int SYNC_STAGES = 2;
  localparam int WORDS       = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic       sclk_in;
  logic       sdata_in;
  logic [3:0] cpu_pc;
  logic [3:0] mem_address;
  logic [3:0] mem_opcode;
  logic [3:0] mem_immediate;
  logic       mem_write;
  logic       cpu_run;
  logic       load_done;
  logic [3:0] word_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  mem_m[16];
  logic        prev_mw = 1'b0;
  logic [3:0]  last_imm = 4'h0;
  logic [3:0]  last_op  = 4'h0;

  td4_prog_loader #(.SYNC_STAGES(SYNC_STAGES), .WORDS(WORDS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_en         (ld_en),
    .sclk_in       (sclk_in),
    .sdata_in      (sdata_in),
    .cpu_pc        (cpu_pc),
    .mem_address   (mem_address),
    .mem_opcode    (mem_opcode),
    .mem_immediate (mem_immediate),
    .mem_write     (mem_write),
    .cpu_run       (cpu_run),
    .load_done     (load_done),
    .word_cnt      (word_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // program memory model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_m[i] <= 8'h00;
    end else if (mem_write) begin
      mem_m[mem_address] <= {mem_immediate, mem_opcode};
    end
  end

  // write scoreboard
  always @(negedge clk) begin
    if (rst_n && mem_write) begin
      check("wr_single_cycle", prev_mw, 1'b0);
      check("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("wr_addr_data", {mem_address, mem_immediate, mem_opcode}, exp_q.pop_front());
      end
      last_imm = mem_immediate;
      last_op  = mem_opcode;
    end
    prev_mw = mem_write;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit noisy);
    if (noisy) begin
      sdata_in = ~b; tick(1);
      sdata_in = b;  tick(1);
      sdata_in = ~b; tick(1);
    end
    sdata_in = b;
    tick(2);
    sclk_in = 1'b1;
    tick(3);
    if (noisy) sdata_in = ~b;
    tick(1);
    sclk_in = 1'b0;
    tick(1);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input bit noisy);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i], noisy);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit noisy);
    send_bits(v, 8, noisy);
    tick(3);
  endtask

  initial begin
    rst_n    = 1'b0;
    ld_en    = 1'b0;
    sclk_in  = 1'b0;
    sdata_in = 1'b0;
    cpu_pc   = 4'hA;
    tick(3);
    check("rst_mem_address", mem_address, 4'hA);
    check("rst_cpu_run", cpu_run, 1'b1);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_word_cnt", word_cnt, 4'h0);
    check("rst_opcode", mem_opcode, 4'h0);
    check("rst_immediate", mem_immediate, 4'h0);
    rst_n = 1'b1;
    tick(2);
    check("run_addr_follow", mem_address, 4'hA);

    // full 16-word load
    ld_en = 1'b1;
    tick(4);
    check("load_cpu_held", cpu_run, 1'b0);
    check("load_addr_ptr", mem_address, 4'h0);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({4'(k), 8'h30 + 8'(k)});
      send_byte(8'h30 + 8'(k), 1'b0);
      if (k == 4) check("cnt_after_5", word_cnt, 4'h5);
      if (k == 5) begin
        check("addr5_immediate", last_imm, 4'h3);
        check("addr5_opcode", last_op, 4'h5);
      end
    end
    check("full_load_done", load_done, 1'b1);
    check("full_word_cnt", word_cnt, 4'hF);
    check("full_cpu_held", cpu_run, 1'b0);
    check("full_no_write", mem_write, 1'b0);
    check("full_q_drained", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) check("readback", mem_m[i], 8'h30 + 8'(i));

    // DONE ignores further serial traffic
    send_byte(8'hC3, 1'b1);
    send_byte(8'h5A, 1'b0);
    check("done_hold", load_done, 1'b1);
    check("done_cnt_hold", word_cnt, 4'hF);
    check("done_mem0", mem_m[0], 8'h30);
    ld_en = 1'b0;
    tick(SYNC_STAGES + 1);
    check("release_cpu_run", cpu_run, 1'b1);
    check("release_load_done", load_done, 1'b0);
    cpu_pc = 4'h3;
    #1;
    check("release_addr_pc", mem_address, 4'h3);

    // abort after three bits
    tick(1);
    ld_en = 1'b1;
    tick(4);
    check("abort_entry_held", cpu_run, 1'b0);
    send_bits(8'hA0, 3, 1'b0);
    ld_en = 1'b0;
    begin
      int i = 0;
      while (cpu_run !== 1'b1 && i < SYNC_STAGES + 1) begin
        tick(1);
        i++;
      end
    end
    check("abort_run", cpu_run, 1'b1);
    check("abort_word_cnt", word_cnt, 4'h0);
    check("abort_mem0", mem_m[0], 8'h30);
    check("abort_mem15", mem_m[15], 8'h3F);

    // noisy data around edges, then reset mid-word 7
    ld_en = 1'b1;
    tick(4);
    exp_q.push_back({4'h0, 8'hA5});
    send_byte(8'hA5, 1'b1);
    check("noisy_immediate", last_imm, 4'hA);
    check("noisy_opcode", last_op, 4'h5);
    check("noisy_mem0", mem_m[0], 8'hA5);
    for (int k = 1; k < 7; k++) begin
      exp_q.push_back({4'(k), 8'h40 + 8'(k)});
      send_byte(8'h40 + 8'(k), 1'b0);
    end
    check("seven_word_cnt", word_cnt, 4'h7);
    check("seven_mem6", mem_m[6], 8'h46);
    send_bits(8'hFF, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_cpu_run", cpu_run, 1'b1);
    check("midrst_mem_write", mem_write, 1'b0);
    check("midrst_load_done", load_done, 1'b0);
    check("midrst_word_cnt", word_cnt, 4'h0);
    check("midrst_addr_pc", mem_address, 4'h3);
    check("midrst_opcode", mem_opcode, 4'h0);
    check("midrst_immediate", mem_immediate, 4'h0);
    check("midrst_mem3", mem_m[3], 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("reload_addr0", mem_address, 4'h0);
    check("reload_held", cpu_run, 1'b0);
    exp_q.push_back({4'h0, 8'h77});
    send_byte(8'h77, 1'b0);
    check("reload_mem0", mem_m[0], 8'h77);
    check("reload_mem1", mem_m[1], 8'h00);
    check("reload_cnt", word_cnt, 4'h1);
    ld_en = 1'b0;
    tick(4);
    check("final_cpu_run", cpu_run, 1'b1);
    check("final_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
